murax_jtag_host: RTL and testbench
==================================

# murax_jtag_host

JTAG host (TAP driver) for the Murax debug path: it drives TCK, TMS and TDI into a Murax-style JTAG slave port and samples TDO. A bus-side master issues IR-shift, DR-shift, raw-TMS and TAP-reset commands over a valid/ready stream. TCK is generated by dividing `io_mainClk`. Captured TDO bits are returned on a valid/ready response stream. The block sits inside an FPGA test harness or a bridge SoC, opposite the `io_jtag_*` pins of the Murax core.

## Interface
- `CLK_DIV`, default 4: TCK half-period in `io_mainClk` cycles; legal values are 1 to 255.
- `io_mainClk`  in  1  system clock; every flop is clocked on its rising edge.
- `io_asyncReset`  in  1  reset, asynchronous and active-high.
- `io_cmd_valid`  in  1  command offered.
- `io_cmd_ready`  out  1  block idle and able to accept a command.
- `io_cmd_payload_kind`  in  2  command kind: 0 = raw TMS, 1 = DR shift, 2 = IR shift, 3 = TAP reset.
- `io_cmd_payload_length`  in  5  bit count; 1–31 literal, 0 means 32.
- `io_cmd_payload_data`  in  32  bits to send, LSB first: TDI bits for kinds 1 and 2, TMS bits for kind 0.
- `io_rsp_valid`  out  1  response available.
- `io_rsp_ready`  in  1  response consumed.
- `io_rsp_payload_data`  out  32  captured TDO bits; bit i holds the i-th captured bit; unused upper bits are 0.
- `io_jtag_tck`  out  1  generated TCK.
- `io_jtag_tms`  out  1  TMS, registered.
- `io_jtag_tdi`  out  1  TDI, registered.
- `io_jtag_tdo`  in  1  TDO from the target.

## Operation
- Before and after every command other than kind 0, the TAP is in Run-Test/Idle. Kind 0 leaves the TAP wherever the supplied TMS bits take it; the user is responsible for that state.
- Command accept: a command is taken when `io_cmd_valid && io_cmd_ready`.
  - The block latches kind, length (N) and data.
  - `io_cmd_ready` drops the following cycle.
- The whole transfer is one sequence of JTAG bits. Each bit carries a TMS value, a TDI value and a capture flag.
- Bit sequence per kind:
  - DR shift (kind 1):
    - Header: TMS 1,0,0.
    - Shift phase: N bits. TDI = data[i]. TMS = 0, except the last shift bit, which has TMS = 1. Every shift bit is captured.
    - Trailer: TMS 1,0.
    - Total: N+5 bits.
  - IR shift (kind 2): identical to DR shift except the header is TMS 1,1,0,0. Total: N+6 bits.
  - Raw TMS (kind 0): N bits with TMS = data[i] and TDI = 0. All N bits are captured.
  - TAP reset (kind 3): TMS 1,1,1,1,1,0 with TDI = 0. Length and data are ignored. Nothing is captured, so the response is 0.
- FSM states:
  - IDLE: `io_cmd_ready` = 1. Goes to HEADER on accept.
  - HEADER → SHIFT → TRAILER. Kind 0 goes straight to SHIFT. Kind 3 is handled entirely as HEADER bits with no SHIFT or TRAILER.
  - RESP: `io_rsp_valid` = 1. Goes back to IDLE on `io_rsp_ready`.
- Counters:
  - A TCK divider counts 0 to CLK_DIV-1.
  - A bit counter is 6 bits wide.
  - The capture shift register fills at position i, then is right-aligned as captured; no final shift is needed.
- Commands presented while the block is busy are not accepted. `io_cmd_ready` stays 0 from accept until the response handshake completes.

## Timing
- Reset values (asynchronous): `io_jtag_tck` = 0, `io_jtag_tms` = 1, `io_jtag_tdi` = 0, `io_cmd_ready` = 1, `io_rsp_valid` = 0, `io_rsp_payload_data` = 0, FSM = IDLE, all counters = 0.
- Each JTAG bit occupies 2·CLK_DIV cycles, split into two phases:
  - Low phase: CLK_DIV cycles with TCK = 0. TMS and TDI take the new bit's values in the first low cycle.
  - High phase: CLK_DIV cycles with TCK = 1.
- The first low phase starts the cycle after accept.
- TDO sampling: TDO is registered on the `io_mainClk` edge that drives TCK from 0 to 1. This samples the value the target produced after the previous falling TCK edge.
- After the final bit's high phase:
  - TCK returns to 0.
  - `io_rsp_valid` rises that same cycle.
  - TMS holds the last value driven; TDI returns to 0.
- Latency from accept to `io_rsp_valid`: 1 + bits·2·CLK_DIV cycles. For a DR shift of 8 bits with CLK_DIV = 4, that is 1 + 13·8 = 105 cycles.
- Response handshake:
  - `io_rsp_valid` and the data hold stable until `io_rsp_ready` is sampled high.
  - `io_cmd_ready` is 1 in the next cycle.
  - A new command can therefore be accepted no earlier than one cycle after the response handshake.
- If `io_rsp_ready` is already high when `io_rsp_valid` rises, the response lasts exactly one cycle.
- Reset mid-transfer: every output returns to its reset value immediately, the TCK pulse is truncated, and no response is produced. The TAP state is then undefined, so the user issues kind 3.
- CLK_DIV = 1: TCK toggles every cycle, giving a TCK frequency of mainClk/2. The same rules apply.

## Test plan
1. Reset:
   - Assert `io_asyncReset` for 3 cycles with `io_cmd_valid` = 1.
   - Required: outputs hold their reset values and no command is accepted until reset is released.
   - Then `io_cmd_ready` = 1.
2. DR shift:
   - Kind 1, length 8, data 0xA5, CLK_DIV = 4. The TAP model's 8-bit DR is preloaded with 0x3C.
   - Required TMS per bit: 1,0,0,0,0,0,0,0,0,0,1,1,0.
   - Required TDI during shift: 1,0,1,0,0,1,0,1.
   - Required: `io_rsp_payload_data` = 0x0000003C, `io_rsp_valid` at cycle 105 after accept, and the TAP model's DR = 0xA5.
3. IR shift:
   - Kind 2, length 5, data 0x11, with a TAP model whose IR capture value is 0x01.
   - Required: header TMS 1,1,0,0; IR updated to 0x11; response 0x01; 11 bits of TCK.
4. Full-width shift:
   - Kind 1, length 0, data 0xDEADBEEF, through a 32-bit DR preloaded with 0x12345678.
   - Required: 37 TCK pulses, response 0x12345678, DR = 0xDEADBEEF.
5. TAP reset and raw TMS:
   - Kind 3: required TMS 1,1,1,1,1,0, response 0, and the TAP model ends in Run-Test/Idle.
   - Then kind 0, length 3, data 0b011: required TMS 1,1,0 and 3 captured bits.
6. Backpressure and mid-transfer reset:
   - Hold `io_rsp_ready` = 0 for 10 cycles while presenting a second command. Required: `io_rsp_valid` held, data stable, `io_cmd_ready` = 0, second command not taken.
   - Next, assert `io_asyncReset` during the shift bits of a transfer. Required: TCK = 0 in the same cycle and no response produced.

Source files
------------

// File: rtl/murax_jtag_host_if.sv
// Command and response streams between a bus-side master and the JTAG host.
interface murax_jtag_host_if;
  logic        io_cmd_valid;
  logic        io_cmd_ready;
  logic [1:0]  io_cmd_payload_kind;
  logic [4:0]  io_cmd_payload_length;
  logic [31:0] io_cmd_payload_data;
  logic        io_rsp_valid;
  logic        io_rsp_ready;
  logic [31:0] io_rsp_payload_data;

  // The bus-side agent issuing commands and consuming responses
  modport master (
    output io_cmd_valid, io_cmd_payload_kind, io_cmd_payload_length,
           io_cmd_payload_data, io_rsp_ready,
    input  io_cmd_ready, io_rsp_valid, io_rsp_payload_data
  );

  // The JTAG host itself
  modport slave (
    input  io_cmd_valid, io_cmd_payload_kind, io_cmd_payload_length,
           io_cmd_payload_data, io_rsp_ready,
    output io_cmd_ready, io_rsp_valid, io_rsp_payload_data
  );
endinterface

// File: rtl/murax_jtag_host.sv
// JTAG TAP driver: turns IR/DR/raw-TMS/reset commands into TCK/TMS/TDI bit
// sequences and returns the TDO bits captured during the shift phase.
module murax_jtag_host #(
  parameter int CLK_DIV = 4
) (
  input  logic                    io_mainClk,
  input  logic                    io_asyncReset,
  murax_jtag_host_if.slave        bus,
  output logic                    io_jtag_tck,
  output logic                    io_jtag_tms,
  output logic                    io_jtag_tdi,
  input  logic                    io_jtag_tdo
);

  typedef enum logic [2:0] {IDLE, HEADER, SHIFT, TRAILER, RESP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_next;
  logic [5:0]  bit_cnt, bit_cnt_next;
  logic [7:0]  div_cnt;
  logic [1:0]  kind;
  logic [5:0]  len;
  logic [31:0] data;
  logic [31:0] capture;
  logic        tck, tms, tdi;

  logic        accept, busy, div_end, tck_rise, bit_end, phase_last;
  logic [1:0]  eff_kind;
  logic [5:0]  eff_len;
  logic [31:0] eff_data;
  logic        tms_next, tdi_next;

  // TMS value of a given bit, identified by phase and index within that phase
  function automatic logic bit_tms(state_t st, logic [5:0] cnt, logic [1:0] k,
                                   logic [5:0] n, logic [31:0] d);
    logic v;
    v = 1'b0;
    case (st)
      HEADER: begin
        case (k)
          2'd1:    v = (cnt == 6'd0);
          2'd2:    v = (cnt < 6'd2);
          2'd3:    v = (cnt < 6'd5);
          default: v = 1'b0;
        endcase
      end
      SHIFT:   v = (k == 2'd0) ? d[cnt[4:0]] : (cnt == n - 6'd1);
      TRAILER: v = (cnt == 6'd0);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Last header index: DR header is 3 bits, IR header 4, TAP reset 6
  function automatic logic [5:0] header_last(logic [1:0] k);
    case (k)
      2'd2:    return 6'd3;
      2'd3:    return 6'd5;
      default: return 6'd2;
    endcase
  endfunction

  // Event decode; at accept the incoming payload stands in for the latched one
  always_comb begin
    accept   = (state == IDLE) && bus.io_cmd_valid;
    busy     = (state == HEADER) || (state == SHIFT) || (state == TRAILER);
    div_end  = (div_cnt == DIV_LAST);
    tck_rise = busy && !tck && div_end;
    bit_end  = busy && tck && div_end;
    eff_kind = accept ? bus.io_cmd_payload_kind : kind;
    eff_data = accept ? bus.io_cmd_payload_data : data;
    eff_len  = len;
    if (accept) begin
      eff_len = (bus.io_cmd_payload_length == 5'd0) ? 6'd32
                                                    : {1'b0, bus.io_cmd_payload_length};
    end
    case (state)
      HEADER:  phase_last = (bit_cnt == header_last(kind));
      SHIFT:   phase_last = (bit_cnt == len - 6'd1);
      TRAILER: phase_last = (bit_cnt == 6'd1);
      default: phase_last = 1'b0;
    endcase
  end

  // Next state, next bit index and the pin values of the bit about to start
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next   = (bus.io_cmd_payload_kind == 2'd0) ? SHIFT : HEADER;
          bit_cnt_next = 6'd0;
        end
      end
      HEADER: begin
        if (bit_end) begin
          if (phase_last) begin
            state_next   = (kind == 2'd3) ? RESP : SHIFT;
            bit_cnt_next = 6'd0;
          end else begin
            bit_cnt_next = bit_cnt + 6'd1;
          end
        end
      end
      SHIFT: begin
        if (bit_end) begin
          if (phase_last) begin
            state_next   = (kind == 2'd0) ? RESP : TRAILER;
            bit_cnt_next = 6'd0;
          end else begin
            bit_cnt_next = bit_cnt + 6'd1;
          end
        end
      end
      TRAILER: begin
        if (bit_end) begin
          if (phase_last) begin
            state_next   = RESP;
            bit_cnt_next = 6'd0;
          end else begin
            bit_cnt_next = bit_cnt + 6'd1;
          end
        end
      end
      RESP: begin
        if (bus.io_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    tms_next = bit_tms(state_next, bit_cnt_next, eff_kind, eff_len, eff_data);
    tdi_next = (state_next == SHIFT) && (eff_kind != 2'd0) ? eff_data[bit_cnt_next[4:0]] : 1'b0;
  end

  // FSM state and bit index registers
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state   <= IDLE;
      bit_cnt <= 6'd0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  // Command latch, TCK divider, pin registers and TDO capture
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      div_cnt <= 8'd0;
      tck     <= 1'b0;
      tms     <= 1'b1;
      tdi     <= 1'b0;
      kind    <= 2'd0;
      len     <= 6'd0;
      data    <= 32'd0;
      capture <= 32'd0;
    end else if (accept) begin
      kind    <= bus.io_cmd_payload_kind;
      len     <= eff_len;
      data    <= bus.io_cmd_payload_data;
      capture <= 32'd0;
      div_cnt <= 8'd0;
      tck     <= 1'b0;
      tms     <= tms_next;
      tdi     <= tdi_next;
    end else if (busy) begin
      div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
      if (tck_rise) begin
        tck <= 1'b1;
        if (state == SHIFT) capture[bit_cnt[4:0]] <= io_jtag_tdo;
      end
      if (bit_end) begin
        tck <= 1'b0;
        if (state_next == RESP) begin
          tdi <= 1'b0;
        end else begin
          tms <= tms_next;
          tdi <= tdi_next;
        end
      end
    end
  end

  assign bus.io_cmd_ready        = (state == IDLE);
  assign bus.io_rsp_valid        = (state == RESP);
  assign bus.io_rsp_payload_data = capture;
  assign io_jtag_tck             = tck;
  assign io_jtag_tms             = tms;
  assign io_jtag_tdi             = tdi;

endmodule

// File: tb/tb_murax_jtag_host.sv
// Bench for murax_jtag_host: a behavioural TAP target, a pin-level trace of
// every TCK bit, a directed vector table and randomized commands checked
// against a bit-sequence reference model.
module tb_murax_jtag_host;

  localparam int CLK_DIV = 4;

  typedef enum int {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UP_DR,
                    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UP_IR} tap_t;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  len;
    logic [31:0] data;
    int          dr_len;
    logic [31:0] dr_init;
    int          bits;
    logic [63:0] tms;
    logic [63:0] tdi;
    logic [31:0] rsp;
    int          reg_sel;
    logic [31:0] reg_val;
  } vec_t;

  logic io_mainClk = 1'b0;
  logic io_asyncReset = 1'b0;
  logic tck, tms, tdi;
  logic tdo = 1'b0;

  murax_jtag_host_if bus ();

  murax_jtag_host #(.CLK_DIV(CLK_DIV)) dut (
    .io_mainClk    (io_mainClk),
    .io_asyncReset (io_asyncReset),
    .bus           (bus),
    .io_jtag_tck   (tck),
    .io_jtag_tms   (tms),
    .io_jtag_tdi   (tdi),
    .io_jtag_tdo   (tdo)
  );

  always #5 io_mainClk = ~io_mainClk;

  int n_compared = 0;
  int n_mismatched = 0;

  // TAP target model state (written only by the model processes)
  tap_t        tap = TLR;
  logic [31:0] dr = 32'd0;
  logic [31:0] dr_sr = 32'd0;
  logic [4:0]  ir = 5'h01;
  logic [4:0]  ir_sr = 5'h01;
  int          preload_seen = 0;

  // Model configuration (written only by the stimulus process)
  int          dr_len = 8;
  logic [31:0] preload_val = 32'd0;
  int          preload_gen = 0;
  bit          tdo_random = 1'b0;

  // Per-bit pin trace, one entry per rising TCK
  logic tr_tms [4096];
  logic tr_tdi [4096];
  logic tr_tdo [4096];
  int   tr_n = 0;

  int          obs_cycles, obs_bits;
  logic [63:0] obs_tms, obs_tdi, obs_tdo;
  logic [31:0] obs_rsp, ref_rsp;
  logic [2:0]  obs_pins;

  vec_t vecs [6];

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UP_DR  : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UP_DR  : SH_DR;
      UP_DR:   return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UP_IR  : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UP_IR  : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  // Target TAP: registers and state advance on rising TCK
  always @(posedge tck) begin
    logic [31:0] mask;
    mask = (dr_len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dr_len) - 32'd1);
    if (preload_gen != preload_seen) begin
      dr = preload_val;
      preload_seen = preload_gen;
    end
    case (tap)
      CAP_DR: dr_sr = dr & mask;
      SH_DR:  dr_sr = ((dr_sr >> 1) | ({31'd0, tdi} << (dr_len - 1))) & mask;
      UP_DR:  dr = dr_sr;
      CAP_IR: ir_sr = 5'h01;
      SH_IR:  ir_sr = {tdi, ir_sr[4:1]};
      UP_IR:  ir = ir_sr;
      default: ;
    endcase
    tap = tap_next(tap, tms);
  end

  // Target TDO changes after falling TCK
  always @(negedge tck) begin
    if (tdo_random) tdo = 1'($urandom_range(0, 1));
    else if (tap == SH_DR) tdo = dr_sr[0];
    else if (tap == SH_IR) tdo = ir_sr[0];
    else tdo = 1'b0;
  end

  // Record the pins seen by the target at each rising TCK
  always @(posedge tck) begin
    tr_tms[tr_n % 4096] = tms;
    tr_tdi[tr_n % 4096] = tdi;
    tr_tdo[tr_n % 4096] = tdo;
    tr_n++;
  end

  // Bit sequence of a command as the protocol defines it, LSB = first bit
  function automatic int build_ref(input logic [1:0] kind, input logic [4:0] len,
                                   input logic [31:0] data, output logic [63:0] etms,
                                   output logic [63:0] etdi, output logic [63:0] ecap);
    int n, p;
    n = (len == 5'd0) ? 32 : int'(len);
    p = 0;
    etms = '0; etdi = '0; ecap = '0;
    if (kind == 2'd0) begin
      for (int i = 0; i < n; i++) begin
        etms[p] = data[i]; ecap[p] = 1'b1; p++;
      end
    end else if (kind == 2'd3) begin
      etms[5:0] = 6'b011111; p = 6;
    end else begin
      etms[p] = 1'b1; p++;
      if (kind == 2'd2) begin etms[p] = 1'b1; p++; end
      p += 2;
      for (int i = 0; i < n; i++) begin
        etdi[p] = data[i]; etms[p] = (i == n - 1); ecap[p] = 1'b1; p++;
      end
      etms[p] = 1'b1; p += 2;
    end
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one command and run it until the response appears (bounded)
  task automatic applyStimulus(input logic [1:0] kind, input logic [4:0] len,
                               input logic [31:0] data, input bit early);
    int waited, base;
    waited = 0;
    while (!bus.io_cmd_ready && waited < 50) begin @(negedge io_mainClk); waited++; end
    checkOutput("cmd_ready_wait", 64'(bus.io_cmd_ready), 64'd1);
    bus.io_cmd_valid = 1'b1;
    bus.io_cmd_payload_kind = kind;
    bus.io_cmd_payload_length = len;
    bus.io_cmd_payload_data = data;
    bus.io_rsp_ready = early;
    base = tr_n;
    @(posedge io_mainClk);
    @(negedge io_mainClk);
    bus.io_cmd_valid = 1'b0;
    bus.io_cmd_payload_data = $urandom;
    bus.io_cmd_payload_kind = 2'($urandom_range(0, 3));
    obs_cycles = 1;
    while (!bus.io_rsp_valid && obs_cycles < 400) begin
      @(negedge io_mainClk); obs_cycles++;
    end
    obs_bits = tr_n - base;
    obs_rsp = bus.io_rsp_payload_data;
    obs_pins = {tck, tms, tdi};
    obs_tms = '0; obs_tdi = '0; obs_tdo = '0;
    for (int i = 0; i < obs_bits && i < 64; i++) begin
      obs_tms[i] = tr_tms[(base + i) % 4096];
      obs_tdi[i] = tr_tdi[(base + i) % 4096];
      obs_tdo[i] = tr_tdo[(base + i) % 4096];
    end
  endtask

  task automatic checkObserved(input int bits, input logic [63:0] etms,
                               input logic [63:0] etdi, input logic [31:0] ersp);
    ref_rsp = ersp;
    checkOutput("latency", 64'(obs_cycles), 64'(1 + bits * 2 * CLK_DIV));
    checkOutput("tck_pulses", 64'(obs_bits), 64'(bits));
    checkOutput("tms_seq", obs_tms, etms);
    checkOutput("tdi_seq", obs_tdi, etdi);
    checkOutput("rsp_data", 64'(obs_rsp), 64'(ersp));
    checkOutput("end_pins", 64'(obs_pins), {61'd0, 1'b0, etms[bits - 1], 1'b0});
  endtask

  task automatic completeResponse();
    bus.io_rsp_ready = 1'b1;
    @(negedge io_mainClk);
    checkOutput("rsp_done", 64'({bus.io_rsp_valid, bus.io_cmd_ready}), 64'b01);
    bus.io_rsp_ready = 1'b0;
  endtask

  task automatic runRandom(input logic [1:0] kind, input logic [4:0] len,
                           input logic [31:0] data, input bit early);
    logic [63:0] etms, etdi, ecap;
    logic [31:0] ersp;
    int nb, k;
    applyStimulus(kind, len, data, early);
    nb = build_ref(kind, len, data, etms, etdi, ecap);
    ersp = '0; k = 0;
    for (int i = 0; i < nb; i++) if (ecap[i]) begin ersp[k] = obs_tdo[i]; k++; end
    checkObserved(nb, etms, etdi, ersp);
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int base, cyc;
    bit rsp_seen;

    vecs[0] = '{2'd3, 5'd0, 32'hFFFF_FFFF, 0, 32'h0, 6, 64'h1F, 64'h0, 32'h0, 3, 32'(RTI)};
    vecs[1] = '{2'd1, 5'd8, 32'hA5, 8, 32'h3C, 13, 64'hC01, 64'h528, 32'h3C, 1, 32'hA5};
    vecs[2] = '{2'd2, 5'd5, 32'h11, 0, 32'h0, 11, 64'h303, 64'h110, 32'h01, 2, 32'h11};
    vecs[3] = '{2'd1, 5'd0, 32'hDEAD_BEEF, 32, 32'h1234_5678, 37,
                64'h0000_000C_0000_0001, 64'h0000_0006_F56D_F778, 32'h1234_5678, 1, 32'hDEAD_BEEF};
    vecs[4] = '{2'd0, 5'd3, 32'h3, 0, 32'h0, 3, 64'h3, 64'h0, 32'h0, 3, 32'(CAP_IR)};
    vecs[5] = '{2'd3, 5'd7, 32'h1234, 0, 32'h0, 6, 64'h1F, 64'h0, 32'h0, 3, 32'(RTI)};

    bus.io_cmd_valid = 1'b0;
    bus.io_cmd_payload_kind = 2'd0;
    bus.io_cmd_payload_length = 5'd0;
    bus.io_cmd_payload_data = 32'd0;
    bus.io_rsp_ready = 1'b0;

    // Reset with a command already offered
    #2;
    io_asyncReset = 1'b1;
    bus.io_cmd_valid = 1'b1;
    bus.io_cmd_payload_kind = 2'd1;
    bus.io_cmd_payload_length = 5'd8;
    bus.io_cmd_payload_data = 32'hA5;
    repeat (3) begin
      @(negedge io_mainClk);
      checkOutput("reset_vals",
                  64'({tck, tms, tdi, bus.io_cmd_ready, bus.io_rsp_valid, bus.io_rsp_payload_data}),
                  64'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0}));
    end
    io_asyncReset = 1'b0;
    bus.io_cmd_valid = 1'b0;
    repeat (20) @(negedge io_mainClk);
    checkOutput("reset_no_accept", 64'(tr_n), 64'd0);
    checkOutput("ready_after_reset", 64'(bus.io_cmd_ready), 64'd1);

    // Directed vectors through the TAP model
    $display("[TB] directed vectors");
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].dr_len != 0) begin
        dr_len = vecs[v].dr_len;
        preload_val = vecs[v].dr_init;
        preload_gen++;
      end
      applyStimulus(vecs[v].kind, vecs[v].len, vecs[v].data, 1'b0);
      checkObserved(vecs[v].bits, vecs[v].tms, vecs[v].tdi, vecs[v].rsp);
      case (vecs[v].reg_sel)
        1: checkOutput("tap_dr", 64'(dr), 64'(vecs[v].reg_val));
        2: checkOutput("tap_ir", 64'(ir), 64'(vecs[v].reg_val));
        default: checkOutput("tap_state", 64'(int'(tap)), 64'(vecs[v].reg_val));
      endcase
      completeResponse();
    end

    // Randomized commands against the bit-sequence model
    $display("[TB] random commands");
    tdo_random = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [4:0] l;
      l = (i == 0) ? 5'd1 : (i == 1) ? 5'd0 : 5'($urandom_range(0, 31));
      runRandom(2'($urandom_range(0, 3)), l, $urandom, 1'($urandom_range(0, 1)));
      completeResponse();
    end

    // Response backpressure with a second command offered
    $display("[TB] backpressure");
    runRandom(2'd1, 5'd8, 32'h5A, 1'b0);
    bus.io_cmd_valid = 1'b1;
    bus.io_cmd_payload_kind = 2'd3;
    bus.io_cmd_payload_length = 5'd4;
    for (int i = 0; i < 10; i++) begin
      @(negedge io_mainClk);
      checkOutput("bp_hold",
                  64'({bus.io_rsp_valid, bus.io_cmd_ready, bus.io_rsp_payload_data}),
                  64'({1'b1, 1'b0, ref_rsp}));
    end
    bus.io_cmd_valid = 1'b0;
    base = tr_n;
    completeResponse();
    repeat (20) @(negedge io_mainClk);
    checkOutput("bp_not_taken", 64'(tr_n - base), 64'd0);

    // Reset during the shift bits of a DR transfer
    $display("[TB] reset mid-transfer");
    bus.io_cmd_valid = 1'b1;
    bus.io_cmd_payload_kind = 2'd1;
    bus.io_cmd_payload_length = 5'd16;
    bus.io_cmd_payload_data = $urandom;
    base = tr_n;
    @(posedge io_mainClk);
    @(negedge io_mainClk);
    bus.io_cmd_valid = 1'b0;
    cyc = 0;
    while (!((tr_n - base) >= 5 && tck) && cyc < 500) begin @(negedge io_mainClk); cyc++; end
    checkOutput("midreset_reach", 64'(((tr_n - base) >= 5) && tck), 64'd1);
    io_asyncReset = 1'b1;
    #1;
    checkOutput("midreset_pins",
                64'({tck, tms, tdi, bus.io_cmd_ready, bus.io_rsp_valid}),
                64'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0}));
    repeat (2) @(negedge io_mainClk);
    io_asyncReset = 1'b0;
    base = tr_n;
    rsp_seen = 1'b0;
    repeat (300) begin
      @(negedge io_mainClk);
      rsp_seen |= bus.io_rsp_valid;
    end
    checkOutput("midreset_no_rsp", 64'({rsp_seen, 1'(tr_n != base)}), 64'd0);

    // Recover the TAP after the truncated transfer
    tdo_random = 1'b0;
    applyStimulus(2'd3, 5'd0, 32'd0, 1'b1);
    checkObserved(6, 64'h1F, 64'h0, 32'h0);
    checkOutput("recover_tap", 64'(int'(tap)), 64'(int'(RTI)));
    completeResponse();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
